rvc_asap_dmem: RTL

//  Data memory for the single-cycle core: consumes the core's D_MEM outputs
//  (address, store data, byte enables, wr-en, load select, sign-ext) and

---
 rtl/rvc_asap_dmem.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rvc_asap_dmem.sv
// rtl/rvc_asap_dmem.sv - single-cycle core data memory with fault capture and store counter
//
// Purpose:
//    Word-organised data memory for the single-cycle core. Loads are
//    combinational and return aligned, sign/zero-extended data in the same
//    cycle. Stores commit on the rising clock edge. The block also keeps a
//    sticky record of the first faulting access and counts committed stores.
//
// Ports:
//    Clock       in   1   core clock, all state updates on posedge
//    Rst_N       in   1   asynchronous active-low reset
//    Address     in   32  byte address from the core
//    WrData      in   32  store data, unshifted (lane 0 aligned)
//    ByteEn      in   4   0001 byte, 0011 half, 1111 word, 0000 none
//    WrEn        in   1   store request
//    RdEn        in   1   load request
//    SignExt     in   1   1 sign-extends loads, 0 zero-extends
//    RdData      out  32  aligned, extended load data (combinational)
//    ErrClr      in   1   clears the sticky fault record
//    ErrValid    out  1   a faulting access has been recorded
//    ErrAddr     out  32  address of the first faulting access
//    ErrType     out  2   [1] out of range, [0] misaligned or illegal ByteEn
//    ErrIsStore  out  1   first fault was a store
//    StoreCnt    out  32  committed store count, wraps

module rvc_asap_dmem #(
   parameter logic [31:0] DMEM_BASE  = 32'h0001_0000,
   parameter int          DMEM_DEPTH = 1024
) (
   input  logic        Clock,
   input  logic        Rst_N,
   input  logic [31:0] Address,
   input  logic [31:0] WrData,
   input  logic [3:0]  ByteEn,
   input  logic        WrEn,
   input  logic        RdEn,
   input  logic        SignExt,
   output logic [31:0] RdData,
   input  logic        ErrClr,
   output logic        ErrValid,
   output logic [31:0] ErrAddr,
   output logic [1:0]  ErrType,
   output logic        ErrIsStore,
   output logic [31:0] StoreCnt
);

   localparam int IDX_W = $clog2(DMEM_DEPTH);
   // Upper bound computed in 33 bits so a window ending at 2^32 does not wrap.
   localparam logic [32:0] DMEM_LIMIT = {1'b0, DMEM_BASE} + 33'(4 * DMEM_DEPTH);

   logic [31:0] mem [DMEM_DEPTH];

   logic [31:0]      relAddr;
   logic [IDX_W-1:0] idx;
   logic [1:0]       off;
   logic             inRange;
   logic             misaligned;
   logic             legal;
   logic             doStore;
   logic             fault;
   logic [1:0]       faultType;
   logic [3:0]       laneMask;
   logic [31:0]      laneData;
   logic [31:0]      rdWord;
   logic             unusedRelAddr;

   // Address decode. DMEM_BASE is word aligned, so the byte offset inside the
   // word is taken straight from the raw address.
   assign relAddr       = Address - DMEM_BASE;
   assign idx           = relAddr[IDX_W+1:2];
   assign off           = Address[1:0];
   assign unusedRelAddr = ^{relAddr[31:IDX_W+2], relAddr[1:0]};
   assign inRange       = (Address >= DMEM_BASE) && ({1'b0, Address} < DMEM_LIMIT);

   // Only byte, half and word enables are legal; half and word accesses must
   // be naturally aligned. Any other enable pattern counts as misaligned.
   always_comb begin
      misaligned = 1'b0;
      case (ByteEn)
         4'b0000, 4'b0001: misaligned = 1'b0;
         4'b0011:          misaligned = off[0];
         4'b1111:          misaligned = (off != 2'b00);
         default:          misaligned = 1'b1;
      endcase
   end

   assign legal     = inRange && !misaligned && (ByteEn != 4'b0000);
   assign doStore   = WrEn && legal;
   assign fault     = (WrEn || RdEn) && (ByteEn != 4'b0000) && (!inRange || misaligned);
   assign faultType = {!inRange, misaligned};

   // Store lanes: enables and data are shifted up to the addressed byte.
   assign laneMask = ByteEn << off;
   assign laneData = WrData << {off, 3'b000};

   // Memory array is not reset; writes are simply blocked while Rst_N is low
   // so a store presented at a reset edge is dropped.
   always_ff @(posedge Clock) begin
      if (Rst_N && doStore) begin
         for (int i = 0; i < 4; i++) begin
            if (laneMask[i]) begin
               mem[idx][8*i +: 8] <= laneData[8*i +: 8];
            end
         end
      end
   end

   // Load path reads the pre-edge contents, so a same-cycle store is not
   // forwarded.
   assign rdWord = mem[idx] >> {off, 3'b000};

   always_comb begin
      RdData = 32'h0000_0000;
      if (RdEn && legal) begin
         case (ByteEn)
            4'b0001: RdData = {{24{SignExt & rdWord[7]}}, rdWord[7:0]};
            4'b0011: RdData = {{16{SignExt & rdWord[15]}}, rdWord[15:0]};
            default: RdData = rdWord;
         endcase
      end
   end

   // Fault record holds the first fault only. A fault arriving in the same
   // cycle as ErrClr replaces the old record instead of being lost.
   always_ff @(posedge Clock or negedge Rst_N) begin
      if (!Rst_N) begin
         ErrValid   <= 1'b0;
         ErrAddr    <= 32'h0000_0000;
         ErrType    <= 2'b00;
         ErrIsStore <= 1'b0;
         StoreCnt   <= 32'h0000_0000;
      end else begin
         if (fault && (!ErrValid || ErrClr)) begin
            ErrValid   <= 1'b1;
            ErrAddr    <= Address;
            ErrType    <= faultType;
            ErrIsStore <= WrEn;
         end else if (ErrClr) begin
            ErrValid   <= 1'b0;
            ErrAddr    <= 32'h0000_0000;
            ErrType    <= 2'b00;
            ErrIsStore <= 1'b0;
         end
         if (doStore) begin
            StoreCnt <= StoreCnt + 32'd1;
         end
      end
   end

endmodule
